// File: rtl/cond_control_unit.sv
// cond_control_unit: registered ARM decode/control stage with condition evaluation and memory wait-state throttling.
// Optional feature macro COND_EXEC_EN: when defined, the condition field is evaluated against NZCV; otherwise every instruction runs as AL.
module cond_control_unit #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [3:0] cond,
  input  logic [1:0] mode,
  input  logic [3:0] op_code,
  input  logic       s,
  input  logic [3:0] status,
  input  logic       freeze,
  input  logic       flush,
  output logic       ex_valid,
  output logic [3:0] exe_cmd,
  output logic       mem_read,
  output logic       mem_write,
  output logic       wb_en,
  output logic       branch,
  output logic       s_out,
  output logic       cond_pass,
  output logic       illegal,
  output logic       stall_out
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] dec_cmd;
  logic       dec_rd, dec_wr, dec_wb, dec_br, dec_s, dec_ill;
  logic       cond_ok, accept;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    dec_cmd = 4'b0000;
    dec_rd  = 1'b0;
    dec_wr  = 1'b0;
    dec_wb  = 1'b0;
    dec_br  = 1'b0;
    dec_s   = 1'b0;
    dec_ill = 1'b0;
    casez ({mode, op_code})
      6'b00_1101: begin dec_cmd = 4'b0001; dec_wb = 1'b1; dec_s = s; end
      6'b00_1111: begin dec_cmd = 4'b1001; dec_wb = 1'b1; dec_s = s; end
      6'b00_0100: begin dec_cmd = 4'b0010; dec_wb = 1'b1; dec_s = s; end
      6'b00_0101: begin dec_cmd = 4'b0011; dec_wb = 1'b1; dec_s = s; end
      6'b00_0010: begin dec_cmd = 4'b0100; dec_wb = 1'b1; dec_s = s; end
      6'b00_0110: begin dec_cmd = 4'b0101; dec_wb = 1'b1; dec_s = s; end
      6'b00_0000: begin dec_cmd = 4'b0110; dec_wb = 1'b1; dec_s = s; end
      6'b00_1100: begin dec_cmd = 4'b0111; dec_wb = 1'b1; dec_s = s; end
      6'b00_0001: begin dec_cmd = 4'b1000; dec_wb = 1'b1; dec_s = s; end
      6'b00_1010: begin dec_cmd = 4'b0100; dec_s = 1'b1; end
      6'b00_1000: begin dec_cmd = 4'b0110; dec_s = 1'b1; end
      // The S bit doubles as L here: set selects LDR, clear selects STR.
      6'b01_0100: begin
        dec_cmd = 4'b0010;
        dec_rd  = s;
        dec_wr  = ~s;
        dec_wb  = s;
      end
      6'b10_0???: dec_br  = 1'b1;
      default:    dec_ill = 1'b1;
    endcase
  end

`ifdef COND_EXEC_EN
  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = status;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = flag_z;
      4'b0001: cond_ok = ~flag_z;
      4'b0010: cond_ok = flag_c;
      4'b0011: cond_ok = ~flag_c;
      4'b0100: cond_ok = flag_n;
      4'b0101: cond_ok = ~flag_n;
      4'b0110: cond_ok = flag_v;
      4'b0111: cond_ok = ~flag_v;
      4'b1000: cond_ok = flag_c & ~flag_z;
      4'b1001: cond_ok = ~flag_c | flag_z;
      4'b1010: cond_ok = (flag_n == flag_v);
      4'b1011: cond_ok = (flag_n != flag_v);
      4'b1100: cond_ok = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ok = flag_z | (flag_n != flag_v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
`else
  logic unused_cond_inputs;
  assign unused_cond_inputs = ^{cond, status};
  assign cond_ok = 1'b1;
`endif

  assign accept = instr_valid & ~freeze & ~flush & (state_q == IDLE);

  // Freeze does not touch the wait counter; only flush aborts an outstanding wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == WAIT) begin
      if (cnt_q <= CNT_W'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (accept && (dec_rd || dec_wr) && cond_ok && (MEM_WAIT > 0)) begin
      state_d = WAIT;
      cnt_d   = CNT_W'(MEM_WAIT);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ex_valid  <= 1'b0;
      exe_cmd   <= 4'b0000;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      wb_en     <= 1'b0;
      branch    <= 1'b0;
      s_out     <= 1'b0;
      cond_pass <= 1'b0;
      illegal   <= 1'b0;
      stall_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ex_valid  <= accept;
      exe_cmd   <= accept ? dec_cmd : 4'b0000;
      mem_read  <= accept & cond_ok & dec_rd;
      mem_write <= accept & cond_ok & dec_wr;
      wb_en     <= accept & cond_ok & dec_wb;
      branch    <= accept & cond_ok & dec_br;
      s_out     <= accept & cond_ok & dec_s;
      cond_pass <= accept & cond_ok;
      illegal   <= accept & dec_ill;
      stall_out <= (state_d == WAIT);
    end
  end

endmodule

// File: tb/tb_cond_control_unit.sv
// tb_cond_control_unit: three instances (MEM_WAIT = 0, 2, 3) share one stimulus stream and are
// compared every cycle against a behavioural model of the decode, condition and wait-state rules.
module tb_cond_control_unit;

  typedef struct packed {
    logic       ex_valid;
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       branch;
    logic       s_out;
    logic       cond_pass;
    logic       illegal;
    logic       stall_out;
  } out_t;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst, instr_valid, s, freeze, flush;
  logic [3:0] cond, op_code, status;
  logic [1:0] mode;
  logic [NI-1:0][12:0] obs_vec;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy [NI];
  out_t exp_q [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cond_control_unit #(.MEM_WAIT(g == 0 ? 0 : (g == 1 ? 2 : 3)), .CNT_W(4)) u_dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .cond(cond), .mode(mode),
      .op_code(op_code), .s(s), .status(status), .freeze(freeze), .flush(flush),
      .ex_valid(obs_vec[g][12]), .exe_cmd(obs_vec[g][11:8]), .mem_read(obs_vec[g][7]),
      .mem_write(obs_vec[g][6]), .wb_en(obs_vec[g][5]), .branch(obs_vec[g][4]),
      .s_out(obs_vec[g][3]), .cond_pass(obs_vec[g][2]), .illegal(obs_vec[g][1]),
      .stall_out(obs_vec[g][0])
    );
  end

  function automatic int waits(int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic out_t obs(int k);
    return out_t'(obs_vec[k]);
  endfunction

  // Condition truth from the ARM condition table, using plain flag arithmetic.
  function automatic bit cond_holds(logic [3:0] c, logic [3:0] nzcv);
    int n, z, cf, v;
    n = nzcv[3]; z = nzcv[2]; cf = nzcv[1]; v = nzcv[0];
    case (c)
      0: return z == 1;           1: return z == 0;
      2: return cf == 1;          3: return cf == 0;
      4: return n == 1;           5: return n == 0;
      6: return v == 1;           7: return v == 0;
      8: return cf == 1 && z == 0;
      9: return cf == 0 || z == 1;
      10: return n == v;          11: return n != v;
      12: return z == 0 && n == v;
      13: return z == 1 || n != v;
      14: return 1;
      default: return 0;
    endcase
  endfunction

  // Expected ID/EX contents for an accepted instruction (stall_out filled in by the caller).
  function automatic out_t model_decode(logic [1:0] md, logic [3:0] op, logic sb,
                                        logic [3:0] c, logic [3:0] nzcv);
    logic [3:0] dp_op  [11] = '{4'hD, 4'hF, 4'h4, 4'h5, 4'h2, 4'h6, 4'h0, 4'hC, 4'h1, 4'hA, 4'h8};
    logic [3:0] dp_cmd [11] = '{4'h1, 4'h9, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h4, 4'h6};
    out_t r;
    bit   pass;
`ifdef COND_EXEC_EN
    pass = cond_holds(c, nzcv);
`else
    pass = 1;
`endif
    r = '0;
    r.ex_valid  = 1'b1;
    r.cond_pass = pass;
    r.illegal   = 1'b1;
    if (md == 2'd0) begin
      for (int i = 0; i < 11; i++) begin
        if (op == dp_op[i]) begin
          r.illegal = 1'b0;
          r.exe_cmd = dp_cmd[i];
          r.wb_en   = (i < 9);          // CMP and TST only set flags
          r.s_out   = (i < 9) ? sb : 1'b1;
        end
      end
    end else if (md == 2'd1 && op == 4'd4) begin
      r.illegal   = 1'b0;
      r.exe_cmd   = 4'd2;
      r.mem_read  = sb;
      r.mem_write = !sb;
      r.wb_en     = sb;
    end else if (md == 2'd2 && op < 8) begin
      r.illegal = 1'b0;
      r.branch  = 1'b1;
    end
    if (!pass) begin
      r.mem_read = 0; r.mem_write = 0; r.wb_en = 0; r.branch = 0; r.s_out = 0;
    end
    return r;
  endfunction

  // Advance one clock: update the model from the inputs present at the edge, then settle.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      out_t e;
      e = '0;
      if (rst || flush) begin
        busy[k] = 0;
      end else if (freeze || busy[k] > 0) begin
        if (busy[k] > 0) busy[k]--;
      end else if (instr_valid) begin
        e = model_decode(mode, op_code, s, cond, status);
        if ((e.mem_read || e.mem_write) && waits(k) > 0) busy[k] = waits(k);
      end
      e.stall_out = (busy[k] > 0);
      exp_q[k] = e;
    end
    #1;
  endtask

  task automatic drive(logic v, logic [1:0] md, logic [3:0] op, logic sb, logic [3:0] c);
    instr_valid = v; mode = md; op_code = op; s = sb; cond = c;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; freeze = 1'b0; status = 4'h0;
    drive(1'b1, 2'd0, 4'hD, 1'b1, 4'hE);
    tick(); tick();
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (obs(k) !== 13'h0) begin
        n_bad++; $display("FAIL reset_state inst%0d: got %h want 0000", k, obs(k));
      end
    end
    rst = 1'b0;
    drive(1'b1, 2'd1, 4'h4, 1'b1, 4'hE);
    tick();
    drive(1'b0, 2'd0, 4'h0, 1'b0, 4'hE);
    tick();
    rst = 1'b1;
    drive(1'b1, 2'd1, 4'h4, 1'b1, 4'hE);
    tick();
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (obs(k) !== 13'h0) begin
        n_bad++; $display("FAIL reset_mid_wait inst%0d: got %h want 0000", k, obs(k));
      end
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (!(obs(2).ex_valid === 1'b1 && obs(2).mem_read === 1'b1 && obs(2).stall_out === 1'b1)) begin
      n_bad++; $display("FAIL ldr_after_reset: got %h want ex_valid/mem_read/stall_out set", obs(2));
    end
  endtask

  task automatic test_alu();
    drive(1'b1, 2'd0, 4'h4, 1'b1, 4'hE);
    tick();
    n_cmp++;
    if (obs(0) !== 13'b1_0010_00101100) begin
      n_bad++; $display("FAIL add_s1: got %b want 1001000101100", obs(0));
    end
    drive(1'b1, 2'd0, 4'hA, 1'b0, 4'hE);
    tick();
    n_cmp++;
    if (obs(0) !== 13'b1_0100_00001100) begin
      n_bad++; $display("FAIL cmp_s0: got %b want 1010000001100", obs(0));
    end
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (obs(k) !== exp_q[k]) begin
        n_bad++; $display("FAIL alu_model inst%0d: got %h want %h", k, obs(k), exp_q[k]);
      end
    end
  endtask

  task automatic test_mem();
    drive(1'b0, 2'd0, 4'h0, 1'b0, 4'hE);
    repeat (4) tick();
    drive(1'b1, 2'd1, 4'h4, 1'b1, 4'hE);
    tick();
    n_cmp++;
    if (!(obs(0).mem_read === 1'b1 && obs(0).wb_en === 1'b1 && obs(0).mem_write === 1'b0)) begin
      n_bad++; $display("FAIL ldr_ctrl: got %h want mem_read=1 wb_en=1", obs(0));
    end
    drive(1'b1, 2'd1, 4'h4, 1'b0, 4'hE);
    tick();
    n_cmp++;
    if (!(obs(0).mem_write === 1'b1 && obs(0).wb_en === 1'b0 && obs(0).mem_read === 1'b0)) begin
      n_bad++; $display("FAIL str_ctrl: got %h want mem_write=1 wb_en=0", obs(0));
    end
  endtask

  task automatic test_wait();
    logic [1:0] want_ev [4] = '{1, 0, 0, 1};
    logic [1:0] want_st [4] = '{1, 1, 0, 0};
    drive(1'b0, 2'd0, 4'h0, 1'b0, 4'hE);
    repeat (4) tick();
    drive(1'b1, 2'd1, 4'h4, 1'b1, 4'hE);
    tick();
    drive(1'b1, 2'd0, 4'h4, 1'b0, 4'hE);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      n_cmp++;
      if (obs(1).ex_valid !== want_ev[c][0] || obs(1).stall_out !== want_st[c][0]) begin
        n_bad++;
        $display("FAIL wait2_cycle%0d: got ex_valid=%b stall_out=%b want %b/%b", c,
                 obs(1).ex_valid, obs(1).stall_out, want_ev[c][0], want_st[c][0]);
      end
      for (int k = 0; k < NI; k++) begin
        n_cmp++;
        if (obs(k) !== exp_q[k]) begin
          n_bad++; $display("FAIL wait_model inst%0d cyc%0d: got %h want %h", k, c, obs(k), exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_cond();
    logic [3:0] conds [3] = '{4'h1, 4'h0, 4'hF};
    status = 4'b0100;
    drive(1'b0, 2'd0, 4'h0, 1'b0, 4'hE);
    repeat (4) tick();
    foreach (conds[i]) begin
      drive(1'b1, 2'd0, 4'h4, 1'b1, conds[i]);
      tick();
      for (int k = 0; k < NI; k++) begin
        n_cmp++;
        if (obs(k) !== exp_q[k]) begin
          n_bad++; $display("FAIL cond_%h inst%0d: got %h want %h", conds[i], k, obs(k), exp_q[k]);
        end
      end
`ifdef COND_EXEC_EN
      n_cmp++;
      if (obs(0).cond_pass !== (i == 1) || obs(0).wb_en !== (i == 1)) begin
        n_bad++; $display("FAIL cond_lit_%h: got pass=%b wb=%b want %b", conds[i],
                          obs(0).cond_pass, obs(0).wb_en, (i == 1));
      end
`endif
    end
    status = 4'h0;
  endtask

  task automatic test_freeze_flush();
    freeze = 1'b1; flush = 1'b1;
    drive(1'b1, 2'd0, 4'hD, 1'b1, 4'hE);
    tick();
    n_cmp++;
    if (obs(0) !== 13'h0) begin
      n_bad++; $display("FAIL freeze_flush_bubble: got %h want 0000", obs(0));
    end
    freeze = 1'b0; flush = 1'b0;
    drive(1'b1, 2'd1, 4'h4, 1'b0, 4'hE);
    tick();
    n_cmp++;
    if (obs(2).stall_out !== 1'b1 || obs(2).mem_write !== 1'b1) begin
      n_bad++; $display("FAIL str_enter_wait: got %h want mem_write=1 stall_out=1", obs(2));
    end
    flush = 1'b1;
    tick();
    n_cmp++;
    if (obs(2).stall_out !== 1'b0 || obs(2).ex_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_in_wait: got %h want stall_out=0 ex_valid=0", obs(2));
    end
    flush = 1'b0;
    tick();
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (obs(k) !== exp_q[k]) begin
        n_bad++; $display("FAIL after_flush inst%0d: got %h want %h", k, obs(k), exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst    = ($urandom_range(99) < 2);
      flush  = ($urandom_range(99) < 6);
      freeze = ($urandom_range(99) < 10);
      status = 4'($urandom);
      drive(($urandom_range(99) < 85), 2'($urandom_range(2)), 4'($urandom), 1'($urandom),
            4'($urandom));
      if ($urandom_range(3) == 0) begin mode = 2'd1; op_code = 4'd4; end
      tick();
      for (int k = 0; k < NI; k++) begin
        n_cmp++;
        if (obs(k) !== exp_q[k]) begin
          n_bad++; $display("FAIL random c%0d inst%0d: got %h want %h", c, k, obs(k), exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) busy[k] = 0;
    test_reset();
    test_alu();
    test_mem();
    test_wait();
    test_cond();
    test_freeze_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cond_control_unit.md
# cond_control_unit

Registered, condition-aware decode/control stage for the ARM pipeline: decodes mode/opcode/S into execute command and memory, write-back and branch controls, evaluates the 4-bit condition field against NZCV, and drives the ID/EX control register with freeze, flush and memory wait-state throttling. It sits between instruction decode and the EX stage. It replaces the purely combinational control decode with a clocked stage and separates LDR from STR by the L (S) bit.

## Interface
- MEM_WAIT, 0, extra stall cycles inserted after each issued LDR/STR (0..15)
- CNT_W, 4, width of wait-state counter; MEM_WAIT < 2^CNT_W
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  decode holds a valid instruction
- cond  in  4  instruction condition field [31:28]
- mode  in  2  instruction mode field
- op_code  in  4  opcode field
- s  in  1  S bit (L bit for mode 01)
- status  in  4  {N,Z,C,V} from status register
- freeze  in  1  hazard unit: insert bubble, hold decode
- flush  in  1  branch taken: kill decode instruction, abort wait
- ex_valid  out  1  ID/EX entry valid
- exe_cmd  out  4  ALU command
- mem_read, mem_write, wb_en, branch, s_out  out  1 each  registered controls
- cond_pass  out  1  registered condition result
- illegal  out  1  registered undefined-encoding flag
- stall_out  out  1  hold PC and IF/ID (registered)

## Operation
- Decode {mode,op_code}: 001101 MOV→0001; 001111 MVN→1001; 000100 ADD→0010; 000101 ADC→0011; 000010 SUB→0100; 000110 SBC→0101; 000000 AND→0110; 001100 ORR→0111; 000001 EOR→1000; all with wb_en=1, s_out=s. 001010 CMP→0100, 001000 TST→0110: wb_en=0, s_out=1 forced.
- 010100 with s=1 LDR: exe_cmd 0010, mem_read=1, wb_en=1; s=0 STR: exe_cmd 0010, mem_write=1; s_out=0 for both.
- mode=10, op_code[3]=0: branch=1, other controls 0.
- Anything else: all controls 0, illegal=1, ex_valid=1.
- Condition: EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); AL 1; 1111 → 0.
- Failed condition: ex_valid=1, cond_pass=0, mem_read/mem_write/wb_en/branch/s_out forced 0, exe_cmd still decoded.
- Bubble = all outputs 0 except stall_out.
- FSM states IDLE, WAIT. IDLE: on accepted LDR/STR that passes its condition with MEM_WAIT>0 → WAIT, counter=MEM_WAIT. WAIT: counter decrements each cycle; at 1 → IDLE. stall_out = (state==WAIT).
- Accept = instr_valid & ~freeze & ~flush & state==IDLE.

## Timing
- Reset: all outputs 0, state IDLE, counter 0; rst overrides every other input.
- Latency 1 cycle: inputs sampled at edge t appear on outputs after edge t.
- Priority rst > flush > freeze > WAIT > normal.
- flush: next output bubble; in WAIT → IDLE immediately, stall_out 0 next cycle.
- freeze: next output bubble; FSM and counter unaffected (WAIT still counts).
- WAIT: outputs bubble for exactly MEM_WAIT cycles after the memory op's issue cycle; decode input ignored.
- instr_valid=0 in IDLE: bubble.
- MEM_WAIT=0: WAIT never entered; back-to-back memory ops issue every cycle.
- Failed-condition LDR/STR never enters WAIT.

## Configuration
- COND_EXEC_EN defined: condition evaluation as above.
- Undefined: cond ignored, every instruction treated as AL; cond_pass tied 1 when ex_valid=1 (0 when bubble); status unused.

## Test plan
- Reset mid-WAIT (MEM_WAIT=3): rst high one cycle → all outputs 0, stall_out 0, next LDR accepted normally.
- ADD cond=AL, s=1 → next cycle ex_valid=1, exe_cmd=0010, wb_en=1, s_out=1; CMP s=0 → wb_en=0, s_out=1.
- LDR (mode 01, op 0100, s=1) then STR (s=0) → mem_read=1/wb_en=1, then mem_write=1/wb_en=0.
- MEM_WAIT=2, LDR then ADD held → LDR out, two bubbles with stall_out=1, then ADD out.
- status=0100 (Z=1): ADD cond=NE → cond_pass=0, wb_en=0; cond=EQ → wb_en=1; cond=1111 → cond_pass=0.
- freeze and flush together on a valid MOV → bubble; flush during WAIT → stall_out 0 next cycle.
